// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared defaults and parameter legality helpers for the SDR chain
package sdr_pkg;

  localparam int SDR_WIDTH  = 32;
  localparam int SDR_MWIDTH = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r++;
    return r;
  endfunction

  // Every counter must be wide enough to reach its terminal count.
  function automatic bit params_legal(input int sendnth, input int logsendnth,
                                      input int n_data, input int logndata);
    return (sendnth >= 1) && (n_data >= 1) &&
           (clog2(sendnth) <= logsendnth) && (clog2(n_data) <= logndata);
  endfunction

endpackage

// File: rtl/sdr_nth_strobe.sv
// rtl/sdr_nth_strobe.sv - free-running divide-by-SENDNTH counter with a one-cycle strobe
module sdr_nth_strobe #(
  parameter int SENDNTH    = 2,
  parameter int LOGSENDNTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int DW = (LOGSENDNTH < 1) ? 1 : LOGSENDNTH;
  localparam logic [DW-1:0] DIV_LAST = (SENDNTH > 1) ? DW'(SENDNTH - 1) : '0;

  logic [DW-1:0] div_q, div_d;

  always_comb begin
    tick_o = (div_q == DIV_LAST);
    div_d  = tick_o ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/sdr_data_source.sv
// rtl/sdr_data_source.sv - self-timed index/pass test-pattern source; SDR_DATA_SOURCE_ONESHOT_EN stops after pass 0
module sdr_data_source
  import sdr_pkg::*;
#(
  parameter int SENDNTH    = 2,
  parameter int LOGSENDNTH = 1,
  parameter int WIDTH      = SDR_WIDTH,
  parameter int MWIDTH     = SDR_MWIDTH,
  parameter int N_DATA     = 16,
  parameter int LOGNDATA   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              out_nd,
  output logic [WIDTH-1:0]  out_data,
  output logic [MWIDTH-1:0] out_m,
  output logic              error,
  output logic              first
);

  localparam int IW = (LOGNDATA < 1) ? 1 : LOGNDATA;
  localparam bit PARAMS_OK = params_legal(SENDNTH, LOGSENDNTH, N_DATA, LOGNDATA);
  localparam logic [IW-1:0] IDX_LAST = (N_DATA > 0) ? IW'(N_DATA - 1) : '0;
  localparam logic [31:0]   IDX_MAX  = (N_DATA > 0) ? 32'(N_DATA - 1) : '0;

  logic              tick;
  logic [IW-1:0]     idx_q, idx_d;
  logic [MWIDTH-1:0] pass_q, pass_d;
  logic              out_nd_q, out_nd_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [MWIDTH-1:0] out_m_q, out_m_d;
  logic              first_q, first_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              idx_oob, fault, emit, last, stop_after;

  sdr_nth_strobe #(
    .SENDNTH   (SENDNTH),
    .LOGSENDNTH(LOGSENDNTH)
  ) u_strobe (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

`ifdef SDR_DATA_SOURCE_ONESHOT_EN
  assign stop_after = last && (pass_q == '0);
`else
  assign stop_after = 1'b0;
`endif

  always_comb begin
    idx_oob    = (32'(idx_q) > IDX_MAX);
    // Fault is evaluated from the same cycle so a bad build never emits even once.
    fault      = error_q || !PARAMS_OK || idx_oob;
    emit       = tick && !fault && !done_q;
    last       = (idx_q == IDX_LAST);

    idx_d      = idx_q;
    pass_d     = pass_q;
    out_nd_d   = emit;
    out_data_d = out_data_q;
    out_m_d    = out_m_q;
    first_d    = 1'b0;
    error_d    = fault;
    done_d     = done_q || (emit && stop_after);

    if (emit) begin
      out_data_d = WIDTH'(idx_q);
      out_m_d    = pass_q;
      first_d    = (idx_q == '0);
      if (last) begin
        idx_d = '0;
        if (!stop_after) pass_d = pass_q + MWIDTH'(1);
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pass_q     <= '0;
      out_nd_q   <= 1'b0;
      out_data_q <= '0;
      out_m_q    <= '0;
      first_q    <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      out_nd_q   <= out_nd_d;
      out_data_q <= out_data_d;
      out_m_q    <= out_m_d;
      first_q    <= first_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign out_nd   = out_nd_q;
  assign out_data = out_data_q;
  assign out_m    = out_m_q;
  assign first    = first_q;
  assign error    = error_q;

endmodule

// File: tb/tb_sdr_data_source.sv
// tb/tb_sdr_data_source.sv - scoreboard bench for sdr_data_source over four parameter sets
module tb_sdr_data_source;

  typedef struct {
    int          edge_n;
    logic [31:0] data;
    logic [7:0]  m;
    logic        first;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_cnt;
  int   n_vec;
  int   n_miss;
  exp_t q[3][$];
  int   pushed[3];
  int   lim[3];

  logic        nd0, nd1, nd2, nd3;
  logic [31:0] d0, d1, d3;
  logic [2:0]  d2;
  logic        m0, m1, m2, m3;
  logic        e0, e1, e2, e3;
  logic        f0, f1, f2, f3;

  sdr_data_source #(.SENDNTH(2), .LOGSENDNTH(1), .WIDTH(32), .MWIDTH(1), .N_DATA(4), .LOGNDATA(2)) u0 (
    .clk(clk), .rst_n(rst_n), .out_nd(nd0), .out_data(d0), .out_m(m0), .error(e0), .first(f0));
  sdr_data_source #(.SENDNTH(1), .LOGSENDNTH(1), .WIDTH(32), .MWIDTH(1), .N_DATA(3), .LOGNDATA(2)) u1 (
    .clk(clk), .rst_n(rst_n), .out_nd(nd1), .out_data(d1), .out_m(m1), .error(e1), .first(f1));
  sdr_data_source #(.SENDNTH(1), .LOGSENDNTH(1), .WIDTH(3), .MWIDTH(1), .N_DATA(12), .LOGNDATA(4)) u2 (
    .clk(clk), .rst_n(rst_n), .out_nd(nd2), .out_data(d2), .out_m(m2), .error(e2), .first(f2));
  sdr_data_source #(.SENDNTH(2), .LOGSENDNTH(1), .WIDTH(32), .MWIDTH(1), .N_DATA(5), .LOGNDATA(2)) u3 (
    .clk(clk), .rst_n(rst_n), .out_nd(nd3), .out_data(d3), .out_m(m3), .error(e3), .first(f3));

  // Hand-computed vectors: {edge, data, meta, first}.
  int p1_u0[6][4] = '{'{1,0,0,1}, '{3,1,0,0}, '{5,2,0,0}, '{7,3,0,0}, '{9,0,1,1}, '{11,1,1,0}};
  int p1_u1[12][4] = '{'{0,0,0,1}, '{1,1,0,0}, '{2,2,0,0}, '{3,0,1,1}, '{4,1,1,0}, '{5,2,1,0},
                       '{6,0,0,1}, '{7,1,0,0}, '{8,2,0,0}, '{9,0,1,1}, '{10,1,1,0}, '{11,2,1,0}};
  int p1_u2[12][4] = '{'{0,0,0,1}, '{1,1,0,0}, '{2,2,0,0}, '{3,3,0,0}, '{4,4,0,0}, '{5,5,0,0},
                       '{6,6,0,0}, '{7,7,0,0}, '{8,0,0,0}, '{9,1,0,0}, '{10,2,0,0}, '{11,3,0,0}};
  int p2_u0[3][4] = '{'{1,0,0,1}, '{3,1,0,0}, '{5,2,0,0}};
  int p2_u1[6][4] = '{'{0,0,0,1}, '{1,1,0,0}, '{2,2,0,0}, '{3,0,1,1}, '{4,1,1,0}, '{5,2,1,0}};
  int p2_u2[6][4] = '{'{0,0,0,1}, '{1,1,0,0}, '{2,2,0,0}, '{3,3,0,0}, '{4,4,0,0}, '{5,5,0,0}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic push(input int k, input int e, input int d, input int m, input int f);
    exp_t x;
    if (pushed[k] < lim[k]) begin
      x.edge_n = e;
      x.data   = 32'(d);
      x.m      = 8'(m);
      x.first  = (f != 0);
      q[k].push_back(x);
    end
    pushed[k]++;
  endtask

  task automatic check(input int k, input logic nd, input logic [31:0] d, input logic [7:0] m,
                       input logic f, input logic err);
    exp_t x;
    int   cur;
    cur = edge_cnt - 1;
    n_vec++;
    if (err !== 1'b0) begin
      n_miss++;
      $display("FAIL error_u%0d edge %0d: got %b, expected 0", k, cur, err);
    end
    n_vec++;
    if (q[k].size() != 0 && q[k][0].edge_n == cur) begin
      x = q[k].pop_front();
      if (nd !== 1'b1 || d !== x.data || m !== x.m || f !== x.first) begin
        n_miss++;
        $display("FAIL strobe_u%0d edge %0d: got nd=%b data=%0d m=%0d first=%b, expected nd=1 data=%0d m=%0d first=%b",
                 k, cur, nd, d, m, f, x.data, x.m, x.first);
      end
    end else if (nd !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_u%0d edge %0d: got nd=%b data=%0d, expected nd=0", k, cur, nd, d);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check(0, nd0, d0, 8'(m0), f0, e0);
      check(1, nd1, d1, 8'(m1), f1, e1);
      check(2, nd2, 32'(d2), 8'(m2), f2, e2);
      n_vec++;
      if (e3 !== 1'b1 || nd3 !== 1'b0) begin
        n_miss++;
        $display("FAIL illegal_u3 edge %0d: got error=%b nd=%b, expected error=1 nd=0", edge_cnt - 1, e3, nd3);
      end
    end
  end

  task automatic set_limits();
    for (int k = 0; k < 3; k++) pushed[k] = 0;
`ifdef SDR_DATA_SOURCE_ONESHOT_EN
    lim[0] = 4; lim[1] = 3; lim[2] = 12;
`else
    lim[0] = 1000; lim[1] = 1000; lim[2] = 1000;
`endif
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);

    set_limits();
    for (int i = 0; i < 6; i++)  push(0, p1_u0[i][0], p1_u0[i][1], p1_u0[i][2], p1_u0[i][3]);
    for (int i = 0; i < 12; i++) push(1, p1_u1[i][0], p1_u1[i][1], p1_u1[i][2], p1_u1[i][3]);
    for (int i = 0; i < 12; i++) push(2, p1_u2[i][0], p1_u2[i][1], p1_u2[i][2], p1_u2[i][3]);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
`ifdef SDR_DATA_SOURCE_ONESHOT_EN
    repeat (100) @(negedge clk);
`endif

    // Mid-pass reset: u0 has just emitted idx 1 of pass 1 and holds idx 2.
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({nd0, d0, m0, f0, e0} !== '0) begin
      n_miss++;
      $display("FAIL async_reset_u0: got nd=%b data=%0d m=%b first=%b error=%b, expected all 0", nd0, d0, m0, f0, e0);
    end
    n_vec++;
    if ({nd1, d1, m1, f1, e1} !== '0) begin
      n_miss++;
      $display("FAIL async_reset_u1: got nd=%b data=%0d m=%b first=%b error=%b, expected all 0", nd1, d1, m1, f1, e1);
    end
    n_vec++;
    if (e3 !== 1'b0) begin
      n_miss++;
      $display("FAIL async_reset_u3: got error=%b, expected 0", e3);
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (q[k].size() != 0) begin
        n_miss++;
        $display("FAIL pending_p1_u%0d: got %0d unmatched, expected 0", k, q[k].size());
        q[k].delete();
      end
    end

    @(negedge clk);
    set_limits();
    for (int i = 0; i < 3; i++) push(0, p2_u0[i][0], p2_u0[i][1], p2_u0[i][2], p2_u0[i][3]);
    for (int i = 0; i < 6; i++) push(1, p2_u1[i][0], p2_u1[i][1], p2_u1[i][2], p2_u1[i][3]);
    for (int i = 0; i < 6; i++) push(2, p2_u2[i][0], p2_u2[i][1], p2_u2[i][2], p2_u2[i][3]);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (q[k].size() != 0) begin
        n_miss++;
        $display("FAIL pending_p2_u%0d: got %0d unmatched, expected 0", k, q[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
